branch_pred_track: RTL and testbench
====================================

BRANCH_PRED_TRACK -- requirements
Module: branch_pred_track

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of in-flight branch entries (power of 2, >=2).
REQ-002 SHALL have parameter AW, default `ADDR_WIDTH, PC width.
REQ-003 SHALL have port cpu_clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port cpu_rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enq_valid  input  1  decoded conditional branch leaving ID.
REQ-006 SHALL have port enq_pred  input  2  2-bit predictor counter captured at fetch for that branch.
REQ-007 SHALL have port enq_pc  input  AW  PC of that branch.
REQ-008 SHALL have port enq_ready  output  1  queue can accept an entry.
REQ-009 SHALL have port branch_ex  input  1  branch resolved in EX this cycle.
REQ-010 SHALL have port branch_taken_ex  input  1  resolved direction.
REQ-011 SHALL have port branch_pc_ex  input  AW  PC of resolved branch.
REQ-012 SHALL have port branch_target_ex  input  AW  resolved taken target.
REQ-013 SHALL have port pipe_flush  input  1  external flush (trap/interrupt).
REQ-014 SHALL have port mispredict_flush  output  1  one-cycle redirect request.
REQ-015 SHALL have port redirect_pc  output  AW  fetch restart address.
REQ-016 SHALL have port queue_empty  output  1  no entries held.
REQ-017 SHALL have port track_err  output  1  sticky tracking error.
REQ-018 SHALL have ports branch_cnt, mispred_cnt  output  32 each  resolved-branch and mispredict counters.

Function
REQ-019 Queue SHALL be a DEPTH-entry FIFO of {pred[1:0], pc} with wrapping read/write pointers and a count 0..DEPTH.
REQ-020 enq_ready SHALL be 1 iff count < DEPTH; a full queue SHALL NOT accept even if a dequeue occurs the same cycle.
REQ-021 enq_valid with enq_ready=0 SHALL be ignored (no state change).
REQ-022 queue_empty SHALL be 1 iff count == 0, combinational from count.
REQ-023 branch_ex with count>0 SHALL pop the head entry; predicted direction = head pred[1].
REQ-024 Mispredict SHALL be branch_taken_ex != head pred[1].
REQ-025 On mispredict, at the next edge: mispredict_flush=1 for exactly one cycle; redirect_pc = branch_target_ex if taken, else branch_pc_ex + 4 (modulo 2^AW); queue cleared (pointers and count to 0).
REQ-026 On mispredict, an enq_valid in the same cycle SHALL be discarded (younger, wrong-path).
REQ-027 Correct prediction: mispredict_flush stays 0, redirect_pc holds its value, simultaneous enqueue and pop SHALL both take effect (count unchanged).
REQ-028 branch_pc_ex != head pc SHALL set track_err and be treated as a mispredict (REQ-025).
REQ-029 branch_ex with count==0 SHALL set track_err, pop nothing, assert no flush, not change counters.
REQ-030 pipe_flush SHALL clear the queue at the next edge and discard same-cycle enq_valid and branch_ex; it SHALL NOT assert mispredict_flush nor change counters; pipe_flush has priority over all other events.
REQ-031 branch_cnt SHALL increment on every popped branch; mispred_cnt on every mispredict (incl. REQ-028); both SHALL saturate at 32'hFFFF_FFFF.
REQ-032 track_err SHALL remain 1 until reset.
REQ-033 All outputs except enq_ready and queue_empty SHALL be registered.

Reset
REQ-034 On cpu_rstn=0, asynchronously: pointers, count=0, enq_ready=1, queue_empty=1, mispredict_flush=0, redirect_pc=0, track_err=0, branch_cnt=0, mispred_cnt=0.
REQ-035 Reset asserted mid-operation SHALL discard all entries and any pending flush; first edge after release SHALL behave as from empty.

Verification
REQ-036 Enqueue pc=0x100 pred=2'b11, then branch_ex taken pc=0x100 target=0x200 -> no flush, branch_cnt=1, mispred_cnt=0, queue_empty=1.
REQ-037 Enqueue pc=0x100 pred=2'b01, branch_ex taken target=0x180 -> next cycle mispredict_flush=1 one cycle, redirect_pc=0x180, mispred_cnt=1; with pred=2'b10 and not-taken -> redirect_pc=0x104.
REQ-038 Enqueue 4 entries -> enq_ready=0; 5th enq plus pop same cycle -> 5th dropped, count=3.
REQ-039 Queue of 3, mispredict on head with simultaneous enq_valid -> queue_empty=1 next cycle, enqueue lost.
REQ-040 branch_ex on empty queue -> track_err=1 sticky, counters 0, no flush; pipe_flush with 2 entries -> queue_empty=1, no mispredict_flush.
REQ-041 Preload branch_cnt to 32'hFFFF_FFFF via forcing, resolve a branch -> stays 32'hFFFF_FFFF; assert cpu_rstn mid-stream -> all outputs at REQ-034 values immediately.

Source files
------------

// File: rtl/branch_pred_track.sv
// ---------------------------------------------------------------------------
// branch_pred_track
//
// Tracks conditional branches between decode and execute so the prediction
// made at fetch can be checked once the branch resolves. Each decoded branch
// is pushed into a small FIFO together with the 2-bit predictor counter it was
// fetched with. When EX resolves a branch, the oldest entry is popped and its
// predicted direction (counter MSB) is compared with the real outcome.
//
// A wrong direction, or a resolved PC that does not match the queue head,
// produces a one-cycle fetch redirect and clears every younger entry.
//
// Ports
//   cpu_clk           clock, rising edge
//   cpu_rstn          asynchronous active-low reset
//   enq_valid         decoded conditional branch leaving ID
//   enq_pred[1:0]     predictor counter captured at fetch for that branch
//   enq_pc[AW-1:0]    PC of that branch
//   enq_ready         queue can accept an entry (combinational)
//   branch_ex         branch resolved in EX this cycle
//   branch_taken_ex   resolved direction
//   branch_pc_ex      PC of resolved branch
//   branch_target_ex  resolved taken target
//   pipe_flush        external flush (trap / interrupt)
//   mispredict_flush  one-cycle redirect request (registered)
//   redirect_pc       fetch restart address (registered, holds between redirects)
//   queue_empty       no entries held (combinational)
//   track_err         sticky tracking error (registered)
//   branch_cnt        resolved-branch counter, saturating
//   mispred_cnt       mispredict counter, saturating
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_pred_track #(
  parameter int DEPTH = 4,
  parameter int AW    = `ADDR_WIDTH
) (
  input  logic          cpu_clk,
  input  logic          cpu_rstn,
  input  logic          enq_valid,
  input  logic [1:0]    enq_pred,
  input  logic [AW-1:0] enq_pc,
  output logic          enq_ready,
  input  logic          branch_ex,
  input  logic          branch_taken_ex,
  input  logic [AW-1:0] branch_pc_ex,
  input  logic [AW-1:0] branch_target_ex,
  input  logic          pipe_flush,
  output logic          mispredict_flush,
  output logic [AW-1:0] redirect_pc,
  output logic          queue_empty,
  output logic          track_err,
  output logic [31:0]   branch_cnt,
  output logic [31:0]   mispred_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry storage. Contents are never reset; only pointers/count define
  // which slots are live.
  logic [1:0]    pred_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [1:0]    head_pred;
  logic [AW-1:0] head_pc;
  logic          pop;
  logic          push;
  logic          pc_err;
  logic          empty_err;
  logic          mispredict;
  logic          unused_pred_lsb;

  assign enq_ready   = (count < FULL_CNT);
  assign queue_empty = (count == '0);

  assign head_pred = pred_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

  // Only the counter MSB (direction) matters here; the LSB rides along so the
  // entry keeps the full counter value.
  assign unused_pred_lsb = head_pred[0];

  // pipe_flush outranks everything: a resolving branch in the same cycle is
  // discarded, so it neither pops, counts nor raises errors.
  assign pop        = branch_ex && !queue_empty && !pipe_flush;
  assign empty_err  = branch_ex &&  queue_empty && !pipe_flush;
  assign pc_err     = pop && (branch_pc_ex != head_pc);
  assign mispredict = pop && ((branch_taken_ex != head_pred[1]) || pc_err);

  // enq_ready is evaluated on the pre-pop count, so a full queue refuses an
  // entry even when a pop frees a slot in the same cycle. An enqueue alongside
  // a mispredict is younger than the bad branch and therefore wrong-path.
  assign push = enq_valid && enq_ready && !pipe_flush && !mispredict;

  always_ff @(posedge cpu_clk) begin
    if (push) begin
      pred_mem[wr_ptr] <= enq_pred;
      pc_mem[wr_ptr]   <= enq_pc;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      mispredict_flush <= 1'b0;
      redirect_pc      <= '0;
      track_err        <= 1'b0;
      branch_cnt       <= '0;
      mispred_cnt      <= '0;
    end else begin
      mispredict_flush <= mispredict;

      if (pipe_flush || mispredict) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end

      // Fall-through address wraps naturally at 2^AW.
      if (mispredict) begin
        redirect_pc <= branch_taken_ex ? branch_target_ex
                                       : (branch_pc_ex + AW'(4));
      end

      if (pc_err || empty_err) begin
        track_err <= 1'b1;
      end

      if (pop && (branch_cnt != 32'hFFFF_FFFF)) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_track.sv
// ---------------------------------------------------------------------------
// tb_branch_pred_track
//
// Directed testbench for branch_pred_track (DEPTH=4, AW=32). A table of
// per-cycle stimulus records with hand-computed post-edge outputs is applied
// in order, followed by short hand-written sequences for counter saturation,
// mid-stream reset and the empty-queue resolve error.
// ---------------------------------------------------------------------------
module tb_branch_pred_track;

  logic        cpu_clk;
  logic        cpu_rstn;
  logic        enq_valid;
  logic [1:0]  enq_pred;
  logic [31:0] enq_pc;
  logic        enq_ready;
  logic        branch_ex;
  logic        branch_taken_ex;
  logic [31:0] branch_pc_ex;
  logic [31:0] branch_target_ex;
  logic        pipe_flush;
  logic        mispredict_flush;
  logic [31:0] redirect_pc;
  logic        queue_empty;
  logic        track_err;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int n_vec;
  int n_err;

  branch_pred_track #(
    .DEPTH(4),
    .AW(32)
  ) dut (
    .cpu_clk          (cpu_clk),
    .cpu_rstn         (cpu_rstn),
    .enq_valid        (enq_valid),
    .enq_pred         (enq_pred),
    .enq_pc           (enq_pc),
    .enq_ready        (enq_ready),
    .branch_ex        (branch_ex),
    .branch_taken_ex  (branch_taken_ex),
    .branch_pc_ex     (branch_pc_ex),
    .branch_target_ex (branch_target_ex),
    .pipe_flush       (pipe_flush),
    .mispredict_flush (mispredict_flush),
    .redirect_pc      (redirect_pc),
    .queue_empty      (queue_empty),
    .track_err        (track_err),
    .branch_cnt       (branch_cnt),
    .mispred_cnt      (mispred_cnt)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic        ev;
    logic [1:0]  ep;
    logic [31:0] epc;
    logic        bx;
    logic        bt;
    logic [31:0] bpc;
    logic [31:0] btg;
    logic        pf;
    logic        x_rdy;
    logic        x_emp;
    logic        x_fl;
    logic [31:0] x_redir;
    logic        x_terr;
    logic [31:0] x_bc;
    logic [31:0] x_mc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ev, input logic [1:0] ep, input logic [31:0] epc,
    input logic bx, input logic bt, input logic [31:0] bpc, input logic [31:0] btg,
    input logic pf,
    input logic x_rdy, input logic x_emp, input logic x_fl, input logic [31:0] x_redir,
    input logic x_terr, input logic [31:0] x_bc, input logic [31:0] x_mc);
    vec_t v;
    v.ev = ev; v.ep = ep; v.epc = epc;
    v.bx = bx; v.bt = bt; v.bpc = bpc; v.btg = btg; v.pf = pf;
    v.x_rdy = x_rdy; v.x_emp = x_emp; v.x_fl = x_fl; v.x_redir = x_redir;
    v.x_terr = x_terr; v.x_bc = x_bc; v.x_mc = x_mc;
    return v;
  endfunction

  task automatic drive(input logic ev, input logic [1:0] ep, input logic [31:0] epc,
                       input logic bx, input logic bt, input logic [31:0] bpc,
                       input logic [31:0] btg, input logic pf);
    enq_valid        = ev;
    enq_pred         = ep;
    enq_pc           = epc;
    branch_ex        = bx;
    branch_taken_ex  = bt;
    branch_pc_ex     = bpc;
    branch_target_ex = btg;
    pipe_flush       = pf;
  endtask

  task automatic check_out(input string name, input logic rdy, input logic emp,
                           input logic fl, input logic [31:0] redir, input logic terr,
                           input logic [31:0] bc, input logic [31:0] mc);
    n_vec++;
    if (enq_ready !== rdy || queue_empty !== emp || mispredict_flush !== fl ||
        redirect_pc !== redir || track_err !== terr || branch_cnt !== bc ||
        mispred_cnt !== mc) begin
      n_err++;
      $display("FAIL %s: got rdy=%b emp=%b flush=%b redir=%h terr=%b bc=%h mc=%h, expected rdy=%b emp=%b flush=%b redir=%h terr=%b bc=%h mc=%h",
               name, enq_ready, queue_empty, mispredict_flush, redirect_pc, track_err,
               branch_cnt, mispred_cnt, rdy, emp, fl, redir, terr, bc, mc);
    end else begin
      $display("ok   %s: rdy=%b emp=%b flush=%b redir=%h terr=%b bc=%0d mc=%0d",
               name, enq_ready, queue_empty, mispredict_flush, redirect_pc, track_err,
               branch_cnt, mispred_cnt);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cpu_rstn = 1'b0;
    drive(0, 2'd0, 32'h0, 0, 0, 32'h0, 32'h0, 0);

    // ev ep  epc           bx bt bpc           btg        pf | rdy emp fl redir         terr bc mc
    vecs.push_back(mk(1, 2'b11, 32'h100,      0, 0, 32'h0,        32'h0,   0, 1, 0, 0, 32'h0,   0, 1-1, 0)); // 1 enq
    vecs.push_back(mk(0, 2'b00, 32'h0,        1, 1, 32'h100,      32'h200, 0, 1, 1, 0, 32'h0,   0, 1, 0));   // 2 correct taken
    vecs.push_back(mk(1, 2'b01, 32'h100,      0, 0, 32'h0,        32'h0,   0, 1, 0, 0, 32'h0,   0, 1, 0));   // 3 enq weak NT
    vecs.push_back(mk(0, 2'b00, 32'h0,        1, 1, 32'h100,      32'h180, 0, 1, 1, 1, 32'h180, 0, 2, 1));   // 4 mispred taken
    vecs.push_back(mk(0, 2'b00, 32'h0,        0, 0, 32'h0,        32'h0,   0, 1, 1, 0, 32'h180, 0, 2, 1));   // 5 flush drops
    vecs.push_back(mk(1, 2'b10, 32'h100,      0, 0, 32'h0,        32'h0,   0, 1, 0, 0, 32'h180, 0, 2, 1));   // 6 enq weak T
    vecs.push_back(mk(0, 2'b00, 32'h0,        1, 0, 32'h100,      32'h999, 0, 1, 1, 1, 32'h104, 0, 3, 2));   // 7 mispred NT
    vecs.push_back(mk(0, 2'b00, 32'h0,        0, 0, 32'h0,        32'h0,   0, 1, 1, 0, 32'h104, 0, 3, 2));   // 8 idle
    vecs.push_back(mk(1, 2'b11, 32'h10,       0, 0, 32'h0,        32'h0,   0, 1, 0, 0, 32'h104, 0, 3, 2));   // 9 fill 1
    vecs.push_back(mk(1, 2'b11, 32'h20,       0, 0, 32'h0,        32'h0,   0, 1, 0, 0, 32'h104, 0, 3, 2));   // 10 fill 2
    vecs.push_back(mk(1, 2'b11, 32'h30,       0, 0, 32'h0,        32'h0,   0, 1, 0, 0, 32'h104, 0, 3, 2));   // 11 fill 3
    vecs.push_back(mk(1, 2'b11, 32'h40,       0, 0, 32'h0,        32'h0,   0, 0, 0, 0, 32'h104, 0, 3, 2));   // 12 full
    vecs.push_back(mk(1, 2'b11, 32'h50,       1, 1, 32'h10,       32'h77,  0, 1, 0, 0, 32'h104, 0, 4, 2));   // 13 5th dropped, cnt 3
    vecs.push_back(mk(1, 2'b11, 32'h60,       1, 0, 32'h20,       32'h0,   0, 1, 1, 1, 32'h24,  0, 5, 3));   // 14 mispred + enq lost
    vecs.push_back(mk(0, 2'b00, 32'h0,        0, 0, 32'h0,        32'h0,   0, 1, 1, 0, 32'h24,  0, 5, 3));   // 15 still empty
    vecs.push_back(mk(1, 2'b00, 32'hA0,       0, 0, 32'h0,        32'h0,   0, 1, 0, 0, 32'h24,  0, 5, 3));   // 16 enq NT
    vecs.push_back(mk(1, 2'b00, 32'hB0,       1, 0, 32'hA0,       32'h0,   0, 1, 0, 0, 32'h24,  0, 6, 3));   // 17 enq+pop
    vecs.push_back(mk(0, 2'b00, 32'h0,        1, 0, 32'hB0,       32'h0,   0, 1, 1, 0, 32'h24,  0, 7, 3));   // 18 pop last
    vecs.push_back(mk(1, 2'b11, 32'h400,      0, 0, 32'h0,        32'h0,   0, 1, 0, 0, 32'h24,  0, 7, 3));   // 19 enq
    vecs.push_back(mk(0, 2'b00, 32'h0,        1, 1, 32'h404,      32'h500, 0, 1, 1, 1, 32'h500, 1, 8, 4));   // 20 pc mismatch
    vecs.push_back(mk(1, 2'b11, 32'h300,      0, 0, 32'h0,        32'h0,   0, 1, 0, 0, 32'h500, 1, 8, 4));   // 21 enq
    vecs.push_back(mk(1, 2'b11, 32'h304,      0, 0, 32'h0,        32'h0,   0, 1, 0, 0, 32'h500, 1, 8, 4));   // 22 enq
    vecs.push_back(mk(1, 2'b11, 32'h308,      1, 0, 32'h300,      32'h0,   1, 1, 1, 0, 32'h500, 1, 8, 4));   // 23 pipe_flush wins
    vecs.push_back(mk(1, 2'b11, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'h0,   0, 1, 0, 0, 32'h500, 1, 8, 4));   // 24 enq top pc
    vecs.push_back(mk(0, 2'b00, 32'h0,        1, 0, 32'hFFFF_FFFC, 32'h0,  0, 1, 1, 1, 32'h0,   1, 9, 5));   // 25 pc+4 wraps
    vecs.push_back(mk(0, 2'b00, 32'h0,        0, 0, 32'h0,        32'h0,   0, 1, 1, 0, 32'h0,   1, 9, 5));   // 26 idle

    // Reset state while reset is held.
    #12;
    check_out("reset_state", 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ev, vecs[i].ep, vecs[i].epc, vecs[i].bx, vecs[i].bt,
            vecs[i].bpc, vecs[i].btg, vecs[i].pf);
      step();
      check_out($sformatf("vec%0d", i + 1), vecs[i].x_rdy, vecs[i].x_emp, vecs[i].x_fl,
                vecs[i].x_redir, vecs[i].x_terr, vecs[i].x_bc, vecs[i].x_mc);
    end
    drive(0, 2'd0, 32'h0, 0, 0, 32'h0, 32'h0, 0);

    // Saturation: preload branch_cnt at the top and resolve one more branch.
    #2;
    force dut.branch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt;
    #1;
    check_out("sat_preload", 1, 1, 0, 32'h0, 1, 32'hFFFF_FFFF, 32'd5);
    drive(1, 2'b11, 32'h700, 0, 0, 32'h0, 32'h0, 0);
    step();
    drive(0, 2'b00, 32'h0, 1, 1, 32'h700, 32'h800, 0);
    step();
    check_out("sat_hold", 1, 1, 0, 32'h0, 1, 32'hFFFF_FFFF, 32'd5);

    // Mid-stream reset with a redirect pending and an entry queued.
    drive(1, 2'b00, 32'h900, 0, 0, 32'h0, 32'h0, 0);
    step();
    drive(1, 2'b00, 32'h904, 1, 1, 32'h900, 32'hA00, 0);
    step();
    check_out("pre_reset_flush", 1, 1, 1, 32'hA00, 1, 32'hFFFF_FFFF, 32'd6);
    drive(1, 2'b11, 32'h908, 0, 0, 32'h0, 32'h0, 0);
    step();
    check_out("pre_reset_enq", 1, 0, 0, 32'hA00, 1, 32'hFFFF_FFFF, 32'd6);
    #2;
    cpu_rstn = 1'b0;
    #1;
    check_out("async_reset", 1, 1, 0, 32'h0, 0, 32'h0, 32'h0);
    drive(0, 2'b00, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;

    // First edge after release: resolve on an empty queue -> sticky error only.
    drive(0, 2'b00, 32'h0, 1, 1, 32'h908, 32'hB00, 0);
    step();
    check_out("empty_resolve", 1, 1, 0, 32'h0, 1, 32'h0, 32'h0);
    drive(1, 2'b11, 32'h20, 0, 0, 32'h0, 32'h0, 0);
    step();
    check_out("post_reset_enq", 1, 0, 0, 32'h0, 1, 32'h0, 32'h0);
    drive(0, 2'b00, 32'h0, 1, 1, 32'h20, 32'h40, 0);
    step();
    check_out("post_reset_pop", 1, 1, 0, 32'h0, 1, 32'd1, 32'h0);
    drive(0, 2'b00, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    step();
    check_out("err_sticky", 1, 1, 0, 32'h0, 1, 32'd1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
